// File: rtl/seq_muldiv_if.sv
// Operand/result bundle between the ALU stage and the sequential multiply/divide unit.
// The requester drives start/op/operands; the unit returns the Z pair and status.
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] Zhigh_out;
    logic [WIDTH-1:0] Zlow_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a_in, b_in,
        input  Zhigh_out, Zlow_out, busy, done, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output Zhigh_out, Zlow_out, busy, done, div_zero
    );
endinterface

// File: rtl/seq_muldiv.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// One iteration per clock; the Z outputs only change on the FIX cycle or on clear.
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         clear,
    seq_muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    op_q, op_d;
    logic                    sa_q, sa_d;
    logic                    sb_q, sb_d;
    logic                    bz_q, bz_d;
    logic                    qm1_q, qm1_d;
    logic                    dz_q, dz_d;
    logic [WIDTH-1:0]        araw_q, araw_d;
    logic [WIDTH-1:0]        qr_q, qr_d;
    logic [WIDTH-1:0]        zhigh_q, zhigh_d;
    logic [WIDTH-1:0]        zlow_q, zlow_d;
    logic signed [WIDTH:0]   acc_q, acc_d;
    logic signed [WIDTH:0]   m_q, m_d;

    logic                    load;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH:0]   booth_sum;
    logic [WIDTH:0]          div_shift;
    logic [WIDTH+1:0]        div_trial;

    // |0x80..0| stays 0x80..0, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign load = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_RUN:   busy = 1'b1;
            S_FIX:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-value logic
    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        qm1_d   = qm1_q;
        dz_d    = dz_q;
        araw_d  = araw_q;
        qr_d    = qr_q;
        zhigh_d = zhigh_q;
        zlow_d  = zlow_q;
        acc_d   = acc_q;
        m_d     = m_q;

        booth_sum = acc_q;
        case ({qr_q[0], qm1_q})
            2'b10:   booth_sum = acc_q - m_q;
            2'b01:   booth_sum = acc_q + m_q;
            default: booth_sum = acc_q;
        endcase

        // Remainder never exceeds WIDTH bits, so the top accumulator bit can be dropped on shift.
        div_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {1'b0, m_q};

        if (load) begin
            op_d   = bus.op;
            sa_d   = bus.a_in[WIDTH-1];
            sb_d   = bus.b_in[WIDTH-1];
            bz_d   = (bus.b_in == '0);
            araw_d = bus.a_in;
            acc_d  = '0;
            qm1_d  = 1'b0;
            cnt_d  = CW'(WIDTH - 1);
            if (!bus.op) begin
                qr_d = bus.b_in;
                m_d  = {bus.a_in[WIDTH-1], bus.a_in};
            end else begin
                qr_d = magnitude(bus.a_in);
                m_d  = {1'b0, magnitude(bus.b_in)};
            end
        end else if (state_q == S_RUN) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            if (!op_q) begin
                acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};
                qm1_d = qr_q[0];
            end else begin
                acc_d = div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
                qr_d  = {qr_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
            end
        end else if (state_q == S_FIX) begin
            if (!op_q) begin
                zhigh_d = acc_q[WIDTH-1:0];
                zlow_d  = qr_q;
                dz_d    = 1'b0;
            end else if (bz_q) begin
                zhigh_d = araw_q;
                zlow_d  = '1;
                dz_d    = 1'b1;
            end else begin
                zhigh_d = cond_neg(acc_q[WIDTH-1:0], sa_q);
                zlow_d  = cond_neg(qr_q, sa_q ^ sb_q);
                dz_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_q   <= '0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            qm1_q   <= 1'b0;
            dz_q    <= 1'b0;
            araw_q  <= '0;
            qr_q    <= '0;
            zhigh_q <= '0;
            zlow_q  <= '0;
            acc_q   <= '0;
            m_q     <= '0;
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            qm1_q   <= qm1_d;
            dz_q    <= dz_d;
            araw_q  <= araw_d;
            qr_q    <= qr_d;
            zhigh_q <= zhigh_d;
            zlow_q  <= zlow_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
        end
    end

    assign bus.Zhigh_out = zhigh_q;
    assign bus.Zlow_out  = zlow_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv: expected results are queued at issue time and
// popped by an independent monitor on every done pulse.
module tb_seq_muldiv;

    logic clock;
    logic clear;

    seq_muldiv_if #(.WIDTH(32)) bus ();

    seq_muldiv #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] zh;
        logic [31:0] zl;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("Zhigh_out", bus.Zhigh_out, e.zh);
                chk("Zlow_out",  bus.Zlow_out,  e.zl);
                chk("div_zero",  {31'd0, bus.div_zero}, {31'd0, e.dz});
            end
        end
    end

    task automatic issue(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] zh, input logic [31:0] zl, input logic dz);
        exp_t e;
        e.zh = zh;
        e.zl = zl;
        e.dz = dz;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a_in  = a;
        bus.b_in  = b;
    endtask

    // Counts edges from the next one; lat is the index of the edge after which done is seen.
    task automatic wait_done(input bit drop, input bit timing, output int lat);
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (drop && i == 0) bus.start = 1'b0;
            if (timing) begin
                chk($sformatf("busy_e%0d", i), {31'd0, bus.busy}, {31'd0, (i <= 32)});
                chk($sformatf("done_e%0d", i), {31'd0, bus.done}, {31'd0, (i == 33)});
            end
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] zh, input logic [31:0] zl, input logic dz,
                          input bit timing);
        int lat;
        issue(op_i, a, b, zh, zl, dz);
        wait_done(1'b1, timing, lat);
        chk("latency", lat, 32'd33);
    endtask

    initial begin
        int lat;
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (2) @(negedge clock);
        chk("rst_Zhigh", bus.Zhigh_out, 32'h0);
        chk("rst_Zlow",  bus.Zlow_out,  32'h0);
        chk("rst_busy",  {31'd0, bus.busy},     32'd0);
        chk("rst_done",  {31'd0, bus.done},     32'd0);
        chk("rst_dz",    {31'd0, bus.div_zero}, 32'd0);
        clear = 1'b0;
        @(negedge clock);

        // Multiply with full busy/done timing checks
        run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        chk("done_low_e34", {31'd0, bus.done}, 32'd0);

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);

        // Signed divides
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(1'b1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Start pulse during RUN is ignored
        issue(1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd5;
        bus.b_in  = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(1'b0, 1'b0, lat);
        chk("ignore_latency", lat, 32'd27);

        // Start held through DONE chains a second op
        issue(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
        @(posedge clock);
        @(negedge clock);
        issue(1'b1, 32'd1000, 32'd7, 32'h0000_0006, 32'h0000_008E, 1'b0);
        wait_done(1'b0, 1'b0, lat);
        chk("chain_lat1", lat, 32'd32);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        chk("chain_busy",   {31'd0, bus.busy}, 32'd1);
        chk("chain_Zhold",  bus.Zhigh_out, 32'h0000_0001);
        wait_done(1'b0, 1'b0, lat);
        chk("chain_lat2", lat, 32'd32);

        // Divide by zero, then div_zero holds until the next FIX
        run_op(1'b1, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(1'b0, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 1'b0);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        chk("dz_hold", {31'd0, bus.div_zero}, 32'd1);
        wait_done(1'b0, 1'b0, lat);
        chk("mul_after_dz_lat", lat, 32'd32);
        run_op(1'b1, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Asynchronous clear mid-divide discards the operation
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd50;
        bus.b_in  = 32'd5;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2 clear = 1'b1;
        #1;
        chk("clr_Zhigh", bus.Zhigh_out, 32'h0);
        chk("clr_Zlow",  bus.Zlow_out,  32'h0);
        chk("clr_busy",  {31'd0, bus.busy},     32'd0);
        chk("clr_done",  {31'd0, bus.done},     32'd0);
        chk("clr_dz",    {31'd0, bus.div_zero}, 32'd0);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("clr_busy_held", {31'd0, bus.busy}, 32'd0);
        clear = 1'b0;
        run_op(1'b1, 32'd9, 32'd3, 32'h0000_0000, 32'h0000_0003, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timeout");
    end

endmodule
